// File: rtl/demux_alu.sv
// demux_alu: registered 1-to-4 result demultiplexer.
// Each input word, tagged with a 2-bit select, is steered into one of four
// independent channel FIFOs. Every FIFO drains through its own valid/ready
// handshake, and a per-channel counter tracks how many words were accepted.
module demux_alu #(
  parameter int WIDTH = 8,  // data width of the input and of each channel
  parameter int DEPTH = 2,  // entries per channel FIFO, power of 2, >= 2
  parameter int CNT_W = 8   // width of each accepted-word counter
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         sel_i,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*CNT_W-1:0] count_o
);

  localparam int NCH = 4;
  localparam int AW  = $clog2(DEPTH);
  // Occupancy needs one bit more than a pointer so "full" is representable.
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  // Per-channel FIFO state. Pointers wrap naturally because DEPTH is a power of 2.
  logic [AW-1:0]    wr_ptr_q [NCH];
  logic [AW-1:0]    wr_ptr_d [NCH];
  logic [AW-1:0]    rd_ptr_q [NCH];
  logic [AW-1:0]    rd_ptr_d [NCH];
  logic [AW:0]      occ_q    [NCH];
  logic [AW:0]      occ_d    [NCH];
  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] cnt_d    [NCH];
  logic [WIDTH-1:0] mem_q    [NCH][DEPTH];

  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;

  // Channel status and output presentation, derived only from current state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    full     = '0;
    empty    = '0;
    out_data = '0;
    count_o  = '0;
    for (int k = 0; k < NCH; k++) begin
      full[k]  = (occ_q[k] == FULL_OCC);
      empty[k] = (occ_q[k] == '0);
      out_data[k*WIDTH +: WIDTH] = mem_q[k][rd_ptr_q[k]];
      count_o[k*CNT_W +: CNT_W]  = cnt_q[k];
    end
  end

  // Heads are offered only while enabled; an empty FIFO never offers a word.
  assign out_valid = {4{enb}} & ~empty;

  // Acceptance looks only at the addressed channel, never at out_ready, so a
  // full channel refuses its own words without stalling the other three.
  assign in_ready = enb & ~rst & ~full[sel_i];

  // Handshake decode: one push lane selected by sel_i, four independent pops.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < NCH; k++) begin
      push[k] = in_valid & in_ready & (sel_i == 2'(k));
      pop[k]  = out_valid[k] & out_ready[k];
    end
  end

  // Next-state for pointers, occupancy and counters of every channel.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      occ_d[k]    = occ_q[k];
      cnt_d[k]    = cnt_q[k];
      if (push[k]) begin
        wr_ptr_d[k] = wr_ptr_q[k] + 1'b1;
        // The counter wraps from all-ones back to zero by plain overflow.
        cnt_d[k]    = cnt_q[k] + 1'b1;
      end
      if (pop[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
      end
      // Simultaneous push and pop leave occupancy unchanged.
      case ({push[k], pop[k]})
        2'b10:   occ_d[k] = occ_q[k] + 1'b1;
        2'b01:   occ_d[k] = occ_q[k] - 1'b1;
        default: occ_d[k] = occ_q[k];
      endcase
    end
  end

  // Control state register with synchronous reset; reset discards buffered words.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        occ_q[k]    <= '0;
        cnt_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        occ_q[k]    <= occ_d[k];
        cnt_q[k]    <= cnt_d[k];
      end
    end
  end

  // FIFO storage write port: one entry per accepted word.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; emptiness is tracked by occupancy, so stale
    // entries are never presented as valid and clearing them would only cost logic.
    for (int k = 0; k < NCH; k++) begin
      if (push[k]) begin
        mem_q[k][wr_ptr_q[k]] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_demux_alu.sv
// Self-checking bench for demux_alu with a decoupled scoreboard: the driver
// pushes each accepted word into its channel queue, and a monitor pops and
// compares whenever a channel hands a word to its consumer.
module tb_demux_alu;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               enb;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         sel_i;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] count_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected words per channel, in arrival order.
  logic [WIDTH-1:0] sb_q [4][$];

  demux_alu #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .in_data   (in_data),
    .sel_i     (sel_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count_o   (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] slice(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic [CNT_W-1:0] cnt(input int k);
    return count_o[k*CNT_W +: CNT_W];
  endfunction

  // Monitor: inputs are stable from the falling edge to the next rising edge,
  // so a handshake seen here is the one that completes on that rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (sb_q[k].size() == 0) begin
            check($sformatf("unexpected_pop_ch%0d", k), {56'd0, slice(k)}, 64'hDEAD);
          end else begin
            check($sformatf("pop_data_ch%0d", k), {56'd0, slice(k)}, {56'd0, sb_q[k].pop_front()});
          end
        end
      end
    end
  end

  // Called at the falling edge: records an acceptance, then moves to just after
  // the next rising edge, where the next cycle's inputs are driven.
  task automatic adv();
    if (in_valid && in_ready) sb_q[sel_i].push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) sb_q[k].delete();
    @(negedge clk);
    check("in_ready_during_rst", {63'd0, in_ready}, 64'd0);
    adv();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enb = 1'b1; in_valid = 1'b0; in_data = '0; sel_i = '0; out_ready = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;

    // Reset then idle.
    @(negedge clk);
    check("rst_out_valid", {60'd0, out_valid}, 64'd0);
    check("rst_count", {32'd0, count_o}, 64'd0);
    for (int s = 0; s < 4; s++) begin
      sel_i = 2'(s); #1;
      check($sformatf("idle_in_ready_sel%0d", s), {63'd0, in_ready}, 64'd1);
    end
    adv();

    // Single route to channel C.
    in_valid = 1'b1; in_data = 8'hA5; sel_i = 2'd2; out_ready = 4'b0000;
    @(negedge clk);
    check("route_in_ready", {63'd0, in_ready}, 64'd1);
    adv();
    in_valid = 1'b0;
    @(negedge clk);
    check("route_out_valid", {60'd0, out_valid}, 64'b0100);
    check("route_c_data", {56'd0, slice(2)}, 64'hA5);
    check("route_c_count", {56'd0, cnt(2)}, 64'd1);
    adv();
    out_ready = 4'b0100;
    @(negedge clk);
    adv();
    out_ready = 4'b0000;
    @(negedge clk);
    check("route_drained", {60'd0, out_valid}, 64'd0);
    adv();

    // Full channel B and backpressure.
    in_valid = 1'b1; sel_i = 2'd1; in_data = 8'h11;
    @(negedge clk); adv();
    in_data = 8'h22;
    @(negedge clk); adv();
    in_valid = 1'b0; sel_i = 2'd0;
    @(negedge clk);
    check("full_other_ch_ready", {63'd0, in_ready}, 64'd1);
    sel_i = 2'd1; #1;
    check("full_b_not_ready", {63'd0, in_ready}, 64'd0);
    adv();
    in_valid = 1'b1; in_data = 8'h33; sel_i = 2'd1; out_ready = 4'b0010;
    @(negedge clk);
    check("full_push_refused", {63'd0, in_ready}, 64'd0);
    check("full_head_valid", {60'd0, out_valid}, 64'b0010);
    adv();
    @(negedge clk);
    check("retry_accepted", {63'd0, in_ready}, 64'd1);
    adv();
    in_valid = 1'b0;
    @(negedge clk); adv();
    out_ready = 4'b0000;
    @(negedge clk);
    check("full_drained", {60'd0, out_valid}, 64'd0);
    check("full_b_count", {56'd0, cnt(1)}, 64'd3);
    check("full_sb_empty", 64'(sb_q[1].size()), 64'd0);
    adv();

    // Independence: round-robin, only D drains.
    do_reset();
    out_ready = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sel_i = 2'(i); in_data = 8'(i + 1);
      @(negedge clk); adv();
    end
    in_valid = 1'b0;
    @(negedge clk); adv();
    @(negedge clk);
    check("indep_out_valid", {60'd0, out_valid}, 64'b0111);
    check("indep_a_data", {56'd0, slice(0)}, 64'h01);
    check("indep_b_data", {56'd0, slice(1)}, 64'h02);
    check("indep_c_data", {56'd0, slice(2)}, 64'h03);
    check("indep_counts", {32'd0, count_o}, 64'h01010101);
    adv();
    out_ready = 4'b0111;
    @(negedge clk); adv();
    out_ready = 4'b0000;
    @(negedge clk);
    check("indep_drained", {60'd0, out_valid}, 64'd0);
    adv();

    // enb freeze with one word held on A.
    in_valid = 1'b1; sel_i = 2'd0; in_data = 8'h5A;
    @(negedge clk); adv();
    enb = 1'b0; in_data = 8'h77; out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("frz_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
      check($sformatf("frz_out_valid_%0d", i), {60'd0, out_valid}, 64'd0);
      check($sformatf("frz_counts_%0d", i), {32'd0, count_o}, 64'h01010102);
      adv();
    end
    enb = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("frz_resume_valid", {60'd0, out_valid}, 64'b0001);
    check("frz_resume_data", {56'd0, slice(0)}, 64'h5A);
    adv();
    out_ready = 4'b0000;
    @(negedge clk);
    check("frz_drained", {60'd0, out_valid}, 64'd0);
    check("frz_sb_empty", 64'(sb_q[0].size()), 64'd0);
    adv();

    // Counter wrap on A, draining as it fills.
    do_reset();
    out_ready = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; sel_i = 2'd0; in_data = 8'(i ^ 8'h3C);
      @(negedge clk);
      if (i == 255) check("wrap_count_ff", {56'd0, cnt(0)}, 64'hFF);
      adv();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_count_zero", {56'd0, cnt(0)}, 64'd0);
    adv();
    out_ready = 4'b0000;
    @(negedge clk);
    check("wrap_sb_empty", 64'(sb_q[0].size()), 64'd0);
    adv();

    // Mid-operation reset while B and C hold data.
    in_valid = 1'b1; sel_i = 2'd1; in_data = 8'hB1;
    @(negedge clk); adv();
    sel_i = 2'd2; in_data = 8'hC1;
    @(negedge clk); adv();
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {60'd0, out_valid}, 64'b0110);
    adv();
    do_reset();
    @(negedge clk);
    check("post_rst_valid", {60'd0, out_valid}, 64'd0);
    check("post_rst_counts", {32'd0, count_o}, 64'd0);
    check("post_rst_ready", {63'd0, in_ready}, 64'd1);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_alu.md
Name: demux_alu

Overview:
- Registered 1-to-4 result demultiplexer: the inverse of the 4-to-1 operand mux (A/B/C/D, sel_i, enb).
- Accepts one data stream tagged with a 2-bit select and steers each word into one of four independent channel FIFOs.
- Each channel drains through its own valid/ready handshake.
- Keeps a per-channel count of accepted words. Sits downstream of the mux/ALU path in the mux_alu environment.

Parameters:
- WIDTH, 8, data width of input and each output channel
- DEPTH, 2, entries per channel FIFO (power of 2, >= 2)
- CNT_W, 8, width of each per-channel accepted-word counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- enb  input  1  global enable; low freezes all pushes and pops
- in_data  input  WIDTH  word to route
- sel_i  input  2  destination channel: 0=A, 1=B, 2=C, 3=D
- in_valid  input  1  source has a word on in_data/sel_i
- in_ready  output  1  block accepts the word this cycle
- out_data  output  4*WIDTH  channel heads, packed: [WIDTH-1:0]=A ... [4*WIDTH-1:3*WIDTH]=D
- out_valid  output  4  per-channel head valid, bit0=A
- out_ready  input  4  per-channel consumer ready, bit0=A
- count_o  output  4*CNT_W  per-channel accepted-word counters, packed as out_data

Behaviour:
- Reset: while rst is high at a rising edge, the following happen on that edge:
  - all FIFOs are emptied (pointers and occupancy cleared);
  - count_o is cleared to 0 and out_valid to 0;
  - FIFO storage is not cleared.
- in_ready is 0 while rst is high. Reset mid-operation discards all buffered words; there is no partial drain.
- in_ready (combinational) = enb and not rst and not full[sel_i]. It depends only on current state, enb and sel_i, never on out_ready. No same-cycle bypass.
- Push: when in_valid and in_ready are both high at an edge:
  - in_data is written to FIFO[sel_i];
  - the occupancy of that FIFO increments;
  - count[sel_i] increments and wraps from 2^CNT_W-1 to 0.
- out_valid[k] (combinational) = enb and not empty[k].
- out_data slice k = FIFO[k] head. When out_valid[k] is 0 the slice holds a stale value; benches check it only while out_valid[k] is 1.
- Pop: when out_valid[k] and out_ready[k] are both high at an edge, the head of FIFO[k] is removed. All four channels can pop in the same cycle.
- Latency:
  - a word accepted at edge N is visible on out_valid/out_data at edge N+1 if its FIFO was empty;
  - otherwise it is visible after the earlier words ahead of it are popped.
- Ordering: FIFO order is preserved within each channel. Channels are fully independent, and a full channel never blocks words destined for other channels.
- Simultaneous push and pop on the same channel:
  - Non-full channel: both happen and occupancy is unchanged.
  - Full channel: the pop happens and the push is refused, because in_ready was 0. The word stays on the source for the next cycle.
- Empty channel with out_ready high: nothing happens; occupancy never underflows.
- enb low:
  - in_ready and all out_valid bits go to 0;
  - FIFO contents and counters are held;
  - operation resumes unchanged when enb rises.
- Source rule: in_data and sel_i are held stable while in_valid is high and the word is not accepted. The DUT still re-evaluates in_ready every cycle if sel_i changes.
- Consumer side: while out_valid[k] is high and out_ready[k] is low, out_data slice k is stable.

Test Plan:
- Reset then idle (rst=1 for 2 cycles, then 0, enb=1): out_valid=4'b0000, count_o=0, in_ready=1 with in_valid=0 for any sel_i.
- Single route: push in_data=8'hA5, sel_i=2, out_ready=0 -> next cycle out_valid=4'b0100, C slice=8'hA5, count C=1. Raise out_ready[2] -> next cycle out_valid=0.
- Full/backpressure (DEPTH=2, out_ready=0):
  - push 8'h11, then 8'h22, to sel_i=1 -> in_ready=0 for sel_i=1, but in_ready=1 for sel_i=0;
  - with out_ready[1]=1 and a third push 8'h33 pending on the same edge -> 8'h11 pops, 8'h33 is refused and accepted one cycle later;
  - final drain order on B is 8'h22, 8'h33.
- Independence: round-robin sel_i 0..3 with 8'h01..8'h04 while only out_ready[3]=1 -> D drains 8'h04; A, B and C hold 8'h01, 8'h02, 8'h03 with out_valid high; count_o = 1,1,1,1.
- enb freeze: channel A holds 1 word and enb drops for 3 cycles with in_valid=1 and out_ready=4'b1111 -> in_ready=0, out_valid=0, no count change; after enb=1 the word on A appears and pops.
- Counter wrap and mid-operation reset:
  - 256 accepted words to sel_i=0 (CNT_W=8) -> count A returns to 0;
  - then assert rst for one cycle while B and C hold data -> out_valid=0 and all counts=0 on the next cycle.
